// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the I/D memory-port arbiter: FSM states, owner
// encoding, arbitration-mode encodings and a saturating counter helper.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_DONE = 2'd2
    } arb_state_e;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    localparam int unsigned PRIO_RR      = 0;  // round-robin between I and D
    localparam int unsigned PRIO_FIXED_D = 1;  // D always beats I

    localparam int unsigned STAT_W = 32;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == '1) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection for the memory arbiter. Purely combinational; the result
// is only meaningful while at least one side is pending.
module mem_arb_pick
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned PRIO_MODE = PRIO_RR
) (
    input  logic i_pend,
    input  logic d_pend,
    input  logic last_owner,
    output logic grant_d
);

    // D wins when it is alone, has fixed priority, or I owned the port last
    always_comb begin
        grant_d = 1'b0;
        if (d_pend) begin
            if (!i_pend) begin
                grant_d = 1'b1;
            end else if (PRIO_MODE == PRIO_FIXED_D) begin
                grant_d = 1'b1;
            end else begin
                grant_d = (last_owner == OWN_I);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one 128-bit external memory port between the I-cache (read-only)
// and D-cache (read/write) sides. One transaction at a time; the memory-side
// outputs are registered, the completion pulse goes to the owner only.
// Optional statistics counters are built when MEM_ARB_STAT_EN is defined.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned PRIO_MODE = PRIO_RR,
    parameter int unsigned ADDR_W    = 28,
    parameter int unsigned LINE_W    = 128
) (
    input  logic              clk,
    input  logic              proc_reset,
    input  logic              i_mem_read,
    input  logic [ADDR_W-1:0] i_mem_addr,
    output logic [LINE_W-1:0] i_mem_rdata,
    output logic              i_mem_ready,
    input  logic              d_mem_read,
    input  logic              d_mem_write,
    input  logic [ADDR_W-1:0] d_mem_addr,
    input  logic [LINE_W-1:0] d_mem_wdata,
    output logic [LINE_W-1:0] d_mem_rdata,
    output logic              d_mem_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ready
`ifdef MEM_ARB_STAT_EN
    ,
    output logic [STAT_W-1:0] i_grant_count,
    output logic [STAT_W-1:0] d_grant_count,
    output logic [STAT_W-1:0] i_wait_cycles,
    output logic [STAT_W-1:0] d_wait_cycles
`endif
);

    arb_state_e        state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_owner_q, last_owner_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;

    logic i_pend;
    logic d_pend;
    logic grant_d;
    logic done_now;

    assign i_pend = i_mem_read;
    assign d_pend = d_mem_read | d_mem_write;

    mem_arb_pick #(
        .PRIO_MODE (PRIO_MODE)
    ) u_pick (
        .i_pend     (i_pend),
        .d_pend     (d_pend),
        .last_owner (last_owner_q),
        .grant_d    (grant_d)
    );

    // Next state: grant in IDLE, hold the port in BUSY until memory completes,
    // then one DONE cycle so a requester's late-dropping request is not re-granted
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        case (state_q)
            ARB_IDLE: begin
                if (i_pend || d_pend) begin
                    state_d = ARB_BUSY;
                    if (grant_d) begin
                        owner_d     = OWN_D;
                        mem_addr_d  = d_mem_addr;
                        mem_wdata_d = d_mem_wdata;
                        // An illegal read+write from D is issued as a write
                        mem_write_d = d_mem_write;
                        mem_read_d  = d_mem_read & ~d_mem_write;
                    end else begin
                        owner_d     = OWN_I;
                        mem_addr_d  = i_mem_addr;
                        mem_wdata_d = '0;
                        mem_write_d = 1'b0;
                        mem_read_d  = 1'b1;
                    end
                end
            end
            ARB_BUSY: begin
                if (mem_ready) begin
                    mem_read_d   = 1'b0;
                    mem_write_d  = 1'b0;
                    last_owner_d = owner_q;
                    state_d      = ARB_DONE;
                end
            end
            ARB_DONE: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // FSM and registered memory-port outputs
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state_q      <= ARB_IDLE;
            owner_q      <= OWN_I;
            last_owner_q <= OWN_I;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    // Completion is forwarded only while BUSY; a reset abandons the transfer
    assign done_now    = (state_q == ARB_BUSY) && mem_ready && !proc_reset;
    assign i_mem_ready = done_now && (owner_q == OWN_I);
    assign d_mem_ready = done_now && (owner_q == OWN_D);

    // Both sides see the memory data; each qualifies it with its own ready
    assign i_mem_rdata = mem_rdata;
    assign d_mem_rdata = mem_rdata;

    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    // Flag the illegal simultaneous D read and write in simulation
    always_ff @(posedge clk) begin
        if (!proc_reset) begin
            assert (!(d_mem_read && d_mem_write))
            else $error("mem_arbiter: d_mem_read and d_mem_write asserted together");
        end
    end

`ifdef MEM_ARB_STAT_EN
    logic [STAT_W-1:0] i_gnt_q, i_gnt_d;
    logic [STAT_W-1:0] d_gnt_q, d_gnt_d;
    logic [STAT_W-1:0] i_wait_q, i_wait_d;
    logic [STAT_W-1:0] d_wait_q, d_wait_d;
    logic              i_waiting;
    logic              d_waiting;

    // A side waits while pending but not owning (or about to own) the port;
    // the DONE cycle is not counted
    always_comb begin
        i_waiting = 1'b0;
        d_waiting = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                i_waiting = i_pend && grant_d;
                d_waiting = d_pend && !grant_d;
            end
            ARB_BUSY: begin
                i_waiting = i_pend && (owner_q == OWN_D);
                d_waiting = d_pend && (owner_q == OWN_I);
            end
            default: begin
                i_waiting = 1'b0;
                d_waiting = 1'b0;
            end
        endcase
        i_gnt_d  = i_gnt_q;
        d_gnt_d  = d_gnt_q;
        i_wait_d = i_waiting ? sat_inc(i_wait_q) : i_wait_q;
        d_wait_d = d_waiting ? sat_inc(d_wait_q) : d_wait_q;
        if ((state_q == ARB_IDLE) && (i_pend || d_pend)) begin
            if (grant_d) begin
                d_gnt_d = sat_inc(d_gnt_q);
            end else begin
                i_gnt_d = sat_inc(i_gnt_q);
            end
        end
    end

    // Statistics registers
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            i_gnt_q  <= '0;
            d_gnt_q  <= '0;
            i_wait_q <= '0;
            d_wait_q <= '0;
        end else begin
            i_gnt_q  <= i_gnt_d;
            d_gnt_q  <= d_gnt_d;
            i_wait_q <= i_wait_d;
            d_wait_q <= d_wait_d;
        end
    end

    assign i_grant_count = i_gnt_q;
    assign d_grant_count = d_gnt_q;
    assign i_wait_cycles = i_wait_q;
    assign d_wait_cycles = d_wait_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. Two instances: dut0 round-robin, dut1 fixed
// D priority; the idle one is held in reset and a mux picks the one under test.
// Expected memory transactions are queued when requests are raised and popped
// when the arbiter puts them on the memory port.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    typedef struct {
        logic         own;
        logic         rd;
        logic         wr;
        logic [27:0]  addr;
        logic [127:0] wdata;
        logic [127:0] rdata;
    } txn_t;

    logic         clk;
    logic         rst0, rst1, sel;
    logic         i_mem_read, d_mem_read, d_mem_write;
    logic [27:0]  i_mem_addr, d_mem_addr;
    logic [127:0] d_mem_wdata, mem_rdata;
    logic         mem_ready;

    logic [127:0] i_rdata0, d_rdata0, wdata0, i_rdata1, d_rdata1, wdata1;
    logic         i_rdy0, d_rdy0, rd0, wr0, i_rdy1, d_rdy1, rd1, wr1;
    logic [27:0]  addr0, addr1;
`ifdef MEM_ARB_STAT_EN
    logic [31:0]  i_gc0, d_gc0, i_wc0, d_wc0, i_gc1, d_gc1, i_wc1, d_wc1;
`endif

    mem_arbiter #(.PRIO_MODE(0), .ADDR_W(28), .LINE_W(128)) dut0 (
        .clk (clk), .proc_reset (rst0),
        .i_mem_read (i_mem_read), .i_mem_addr (i_mem_addr),
        .i_mem_rdata (i_rdata0), .i_mem_ready (i_rdy0),
        .d_mem_read (d_mem_read), .d_mem_write (d_mem_write),
        .d_mem_addr (d_mem_addr), .d_mem_wdata (d_mem_wdata),
        .d_mem_rdata (d_rdata0), .d_mem_ready (d_rdy0),
        .mem_read (rd0), .mem_write (wr0), .mem_addr (addr0), .mem_wdata (wdata0),
        .mem_rdata (mem_rdata), .mem_ready (mem_ready)
`ifdef MEM_ARB_STAT_EN
        , .i_grant_count (i_gc0), .d_grant_count (d_gc0),
        .i_wait_cycles (i_wc0), .d_wait_cycles (d_wc0)
`endif
    );

    mem_arbiter #(.PRIO_MODE(1), .ADDR_W(28), .LINE_W(128)) dut1 (
        .clk (clk), .proc_reset (rst1),
        .i_mem_read (i_mem_read), .i_mem_addr (i_mem_addr),
        .i_mem_rdata (i_rdata1), .i_mem_ready (i_rdy1),
        .d_mem_read (d_mem_read), .d_mem_write (d_mem_write),
        .d_mem_addr (d_mem_addr), .d_mem_wdata (d_mem_wdata),
        .d_mem_rdata (d_rdata1), .d_mem_ready (d_rdy1),
        .mem_read (rd1), .mem_write (wr1), .mem_addr (addr1), .mem_wdata (wdata1),
        .mem_rdata (mem_rdata), .mem_ready (mem_ready)
`ifdef MEM_ARB_STAT_EN
        , .i_grant_count (i_gc1), .d_grant_count (d_gc1),
        .i_wait_cycles (i_wc1), .d_wait_cycles (d_wc1)
`endif
    );

    // View of the instance under test
    logic         m_rst, m_rd, m_wr, m_irdy, m_drdy;
    logic [27:0]  m_addr;
    logic [127:0] m_wdata, m_irdata, m_drdata;
    assign m_rst    = sel ? rst1 : rst0;
    assign m_rd     = sel ? rd1 : rd0;
    assign m_wr     = sel ? wr1 : wr0;
    assign m_addr   = sel ? addr1 : addr0;
    assign m_wdata  = sel ? wdata1 : wdata0;
    assign m_irdy   = sel ? i_rdy1 : i_rdy0;
    assign m_drdy   = sel ? d_rdy1 : d_rdy0;
    assign m_irdata = sel ? i_rdata1 : i_rdata0;
    assign m_drdata = sel ? d_rdata1 : d_rdata0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int   n_asserts = 0;
    int   n_fail    = 0;
    txn_t exp_q[$];
    txn_t cur;
    logic busy, rdy_drv, stray;
    logic s_rd, s_wr;
    logic [27:0]  s_addr;
    logic [127:0] s_wdata;
    int   rem, lat, idle_cnt, done_cnt, base;

    task automatic check_b(input string tag, input logic obs, input logic exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_w(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic own, input logic rd, input logic wr, input logic [27:0] addr,
                        input logic [127:0] wdata, input logic [127:0] rdata);
        txn_t t;
        t.own = own; t.rd = rd; t.wr = wr; t.addr = addr; t.wdata = wdata; t.rdata = rdata;
        exp_q.push_back(t);
    endtask

    // One clock: memory responder plus port/ready checks, all on the falling edge
    task automatic tick();
        @(negedge clk);
        mem_ready = 1'b0;
        if (m_rst) begin
            busy = 1'b0; rdy_drv = 1'b0; idle_cnt = 2;
        end else begin
            if (rdy_drv) begin
                rdy_drv = 1'b0; busy = 1'b0; done_cnt++; idle_cnt = 1;
                check_b("release_read", m_rd, 1'b0);
                check_b("release_write", m_wr, 1'b0);
            end else if (busy) begin
                check_b("hold_read", m_rd, s_rd);
                check_b("hold_write", m_wr, s_wr);
                check_w("hold_addr", 128'(m_addr), 128'(s_addr));
                check_w("hold_wdata", m_wdata, s_wdata);
            end else if (m_rd || m_wr) begin
                check_b("grant_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    cur = exp_q.pop_front();
                end else begin
                    cur.own = OWN_I; cur.rdata = '0;
                end
                check_b("grant_read", m_rd, cur.rd);
                check_b("grant_write", m_wr, cur.wr);
                check_w("grant_addr", 128'(m_addr), 128'(cur.addr));
                if (cur.own == OWN_D) check_w("grant_wdata", m_wdata, cur.wdata);
                check_b("idle_gap_ge2", idle_cnt >= 2, 1'b1);
                s_rd = m_rd; s_wr = m_wr; s_addr = m_addr; s_wdata = m_wdata;
                busy = 1'b1; rem = lat;
            end else begin
                idle_cnt++;
            end
            if (busy && !rdy_drv) begin
                rem--;
                if (rem == 0) begin
                    mem_ready = 1'b1; mem_rdata = cur.rdata; rdy_drv = 1'b1;
                end
            end else if (stray) begin
                mem_ready = 1'b1; mem_rdata = 128'hBAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0;
                stray = 1'b0;
            end
        end
        #1;
        check_b("i_ready", m_irdy, rdy_drv && (cur.own == OWN_I));
        check_b("d_ready", m_drdy, rdy_drv && (cur.own == OWN_D));
        check_w("i_rdata_pass", m_irdata, mem_rdata);
        check_w("d_rdata_pass", m_drdata, mem_rdata);
        if (rdy_drv) check_w("owner_rdata", cur.own ? m_drdata : m_irdata, cur.rdata);
    endtask

    task automatic wait_done(input int target, input int budget);
        int n = budget;
        while (done_cnt < target && n > 0) begin
            tick();
            n--;
        end
        check_b("done_in_budget", done_cnt >= target, 1'b1);
    endtask

    task automatic do_reset();
        i_mem_read = 1'b0; d_mem_read = 1'b0; d_mem_write = 1'b0;
        if (sel) rst1 = 1'b1; else rst0 = 1'b1;
        tick(); tick();
        if (sel) rst1 = 1'b0; else rst0 = 1'b0;
        tick();
    endtask

    initial begin
        sel = 1'b0; rst0 = 1'b1; rst1 = 1'b1;
        i_mem_read = 1'b0; d_mem_read = 1'b0; d_mem_write = 1'b0;
        i_mem_addr = '0; d_mem_addr = '0; d_mem_wdata = '0;
        mem_rdata = '0; mem_ready = 1'b0;
        busy = 1'b0; rdy_drv = 1'b0; stray = 1'b0;
        cur.own = OWN_I; cur.rdata = '0;
        rem = 0; lat = 1; idle_cnt = 2; done_cnt = 0;

        // Reset values
        tick(); tick();
        check_b("rst_mem_read", m_rd, 1'b0);
        check_b("rst_mem_write", m_wr, 1'b0);
        check_w("rst_mem_addr", 128'(m_addr), 128'd0);
        check_w("rst_mem_wdata", m_wdata, 128'd0);
        rst0 = 1'b0;
        tick();

        // Single I read, 5-cycle memory latency
        lat = 5; base = done_cnt;
        push(OWN_I, 1'b1, 1'b0, 28'h0000123, '0, 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF);
        i_mem_addr = 28'h0000123; i_mem_read = 1'b1;
        tick();
        check_b("i_read_latency", m_rd, 1'b1);
        check_w("i_read_addr", 128'(m_addr), 128'h0000123);
        wait_done(base + 1, 30);
        i_mem_read = 1'b0;
        tick(); tick();

        // D write
        lat = 4; base = done_cnt;
        d_mem_addr = 28'h0ABCDEF; d_mem_wdata = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
        push(OWN_D, 1'b0, 1'b1, 28'h0ABCDEF, d_mem_wdata, 128'h0000_0000_0000_0000_0000_0000_0000_0D0E);
        d_mem_write = 1'b1;
        wait_done(base + 1, 30);
        d_mem_write = 1'b0;
        tick(); tick();

        // Round-robin: both held from reset, grants must go D, I, D, I
        do_reset();
        lat = 3; base = done_cnt;
        i_mem_addr = 28'h0000111; d_mem_addr = 28'h0000D0D;
        d_mem_wdata = 128'h5A5A_5A5A_5A5A_5A5A_5A5A_5A5A_5A5A_5A5A;
        push(OWN_D, 1'b1, 1'b0, 28'h0000D0D, d_mem_wdata, 128'hA1);
        push(OWN_I, 1'b1, 1'b0, 28'h0000111, '0, 128'hA2);
        push(OWN_D, 1'b1, 1'b0, 28'h0000D0D, d_mem_wdata, 128'hA3);
        push(OWN_I, 1'b1, 1'b0, 28'h0000111, '0, 128'hA4);
        i_mem_read = 1'b1; d_mem_read = 1'b1;
        wait_done(base + 4, 60);
        i_mem_read = 1'b0; d_mem_read = 1'b0;
        tick(); tick();
        check_b("rr_queue_drained", exp_q.size() == 0, 1'b1);
`ifdef MEM_ARB_STAT_EN
        // Each side lost twice; a loss costs the IDLE cycle plus the winner's BUSY cycles
        check_w("i_grant_count", 128'(i_gc0), 128'(2));
        check_w("d_grant_count", 128'(d_gc0), 128'(2));
        check_w("i_wait_cycles", 128'(i_wc0), 128'(2 * (1 + lat)));
        check_w("d_wait_cycles", 128'(d_wc0), 128'(2 * (1 + lat)));
`endif

        // Fixed priority on dut1: D starves I until D drops
        rst0 = 1'b1; sel = 1'b1;
        do_reset();
        lat = 2; base = done_cnt;
        i_mem_addr = 28'h0000EEE; d_mem_addr = 28'h0000DDD;
        d_mem_wdata = 128'hFEED_FACE_CAFE_F00D_FEED_FACE_CAFE_F00D;
        push(OWN_D, 1'b0, 1'b1, 28'h0000DDD, d_mem_wdata, 128'hB1);
        push(OWN_D, 1'b0, 1'b1, 28'h0000DDD, d_mem_wdata, 128'hB2);
        push(OWN_D, 1'b0, 1'b1, 28'h0000DDD, d_mem_wdata, 128'hB3);
        push(OWN_I, 1'b1, 1'b0, 28'h0000EEE, '0, 128'hB4);
        i_mem_read = 1'b1; d_mem_write = 1'b1;
        wait_done(base + 3, 40);
        d_mem_write = 1'b0;
        wait_done(base + 4, 20);
        i_mem_read = 1'b0;
        tick(); tick();
        check_b("prio_queue_drained", exp_q.size() == 0, 1'b1);

        // Reset while BUSY on dut0: transfer abandoned, late ready ignored
        rst1 = 1'b1; sel = 1'b0;
        do_reset();
        lat = 20;
        i_mem_addr = 28'h0000456;
        push(OWN_I, 1'b1, 1'b0, 28'h0000456, '0, 128'hC1);
        i_mem_read = 1'b1;
        tick(); tick();
        check_b("busy_before_reset", m_rd, 1'b1);
        i_mem_read = 1'b0; rst0 = 1'b1;
        tick();
        rst0 = 1'b0;
        check_b("reset_mem_read", m_rd, 1'b0);
        check_b("reset_i_ready", m_irdy, 1'b0);
        check_b("reset_d_ready", m_drdy, 1'b0);
        stray = 1'b1;
        tick();
        tick();
        check_b("no_grant_after_stray", m_rd, 1'b0);
        lat = 2; base = done_cnt;
        d_mem_addr = 28'h0000777; d_mem_wdata = 128'h0;
        push(OWN_D, 1'b1, 1'b0, 28'h0000777, d_mem_wdata, 128'hC2);
        d_mem_read = 1'b1;
        wait_done(base + 1, 20);
        d_mem_read = 1'b0;
        tick(); tick();
        check_b("final_queue_drained", exp_q.size() == 0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single 128-bit external memory port between the instruction-cache side (read-only) and the data-cache side (read/write).
- Sits between icache_wrapper / dcache_wrapper and the top-level memory.
- Grants one requester at a time, holds the grant for one complete transaction, then returns ready/data to the owner only.
- Memory-facing outputs are registered.

Parameters:
- PRIO_MODE, 0, 0 = round-robin between I and D; 1 = fixed priority, D over I.
- ADDR_W, 28, line address width.
- LINE_W, 128, line data width.

Ports:
- clk  in  1  system clock
- proc_reset  in  1  synchronous active-high reset
- i_mem_read  in  1  I-side read request, held until i_mem_ready
- i_mem_addr  in  ADDR_W  I-side line address
- i_mem_rdata  out  LINE_W  I-side read data, valid when i_mem_ready=1
- i_mem_ready  out  1  I-side completion pulse
- d_mem_read  in  1  D-side read request
- d_mem_write  in  1  D-side write request
- d_mem_addr  in  ADDR_W  D-side line address
- d_mem_wdata  in  LINE_W  D-side write data
- d_mem_rdata  out  LINE_W  D-side read data
- d_mem_ready  out  1  D-side completion pulse
- mem_read  out  1  to memory, registered
- mem_write  out  1  to memory, registered
- mem_addr  out  ADDR_W  to memory, registered
- mem_wdata  out  LINE_W  to memory, registered
- mem_rdata  in  LINE_W  from memory
- mem_ready  in  1  from memory, single-cycle completion pulse

Behaviour:
- Clock and reset: one clock (clk); reset proc_reset is synchronous and active-high.
- Reset values:
  - State is IDLE; last_owner is I, so D wins the first round-robin tie.
  - mem_read, mem_write, i_mem_ready and d_mem_ready are 0; mem_addr and mem_wdata are 0.
- States: IDLE, BUSY, DONE.
- IDLE:
  - Samples requests. A requester is pending when i_mem_read=1, or when d_mem_read or d_mem_write is 1.
  - If nothing is pending, stay in IDLE.
  - If exactly one side is pending, grant it.
  - If both are pending and PRIO_MODE=0, grant the side that is not last_owner. If PRIO_MODE=1, grant D.
  - On grant, latch owner and go to BUSY. At the same edge, load mem_addr, mem_wdata and mem_read/mem_write from the owner.
  - Latency: request seen in IDLE at cycle N gives mem_read/mem_write high at N+1.
- BUSY:
  - mem_* are held constant.
  - On mem_ready=1 in cycle M, drive owner_mem_ready=1 and owner_mem_rdata=mem_rdata combinationally in cycle M.
  - The non-owner ready stays 0.
  - At the edge ending M: mem_read=0, mem_write=0, last_owner<=owner, go to DONE.
- DONE:
  - Lasts exactly one cycle and all requests are ignored. This absorbs requesters whose registered request drops one cycle after ready.
  - Then go to IDLE.
- Back-to-back cost: minimum 2 idle cycles on the memory port between transactions (DONE, then IDLE).
- i_mem_rdata and d_mem_rdata: both carry mem_rdata at all times. Consumers qualify with their own ready.
- D-side read and write both asserted: write takes precedence (mem_write=1, mem_read=0). This is illegal per protocol; flagged in simulation.
- mem_ready outside BUSY: ignored, no ready forwarded.
- Requester drops its request while BUSY: the transaction completes anyway and the ready pulse is still delivered.
- Reset asserted mid-transaction: the in-flight transaction is abandoned. Outputs take reset values at the next edge and state goes to IDLE.
- Requests wait with no timeout. Round-robin bounds waiting to one transaction.

Optional Feature:
- Macro: MEM_ARB_STAT_EN.
- When defined, adds four 32-bit outputs:
  - i_grant_count, d_grant_count: increment on each grant.
  - i_wait_cycles, d_wait_cycles: increment each cycle a side is pending but not owner, excluding DONE.
  - All four are cleared by proc_reset and saturate at 0xFFFFFFFF.
- When undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package/header holds:
  - State encodings ARB_IDLE=2'd0, ARB_BUSY=2'd1, ARB_DONE=2'd2.
  - Owner encoding OWN_I=1'b0, OWN_D=1'b1.
  - PRIO_MODE encodings.
- One sub-module, mem_arb_pick: pure combinational winner selection from (i_pend, d_pend, last_owner, PRIO_MODE), with output grant_d.
- The FSM, output registers and optional counters stay in mem_arbiter.

Test Plan:
- Single I read:
  - Stimulus: i_mem_read=1, addr 0x0000123; mem_ready after 5 cycles with rdata 0xDEAD...BEEF.
  - Required: mem_read high 1 cycle after the request, mem_addr=0x0000123; i_mem_ready=1 for exactly the mem_ready cycle with that data; d_mem_ready stays 0; mem_read low next cycle.
- D write:
  - Stimulus: d_mem_write=1, addr 0x0ABCDEF, wdata 0x0123...CDEF.
  - Required: mem_write=1 with that addr/wdata and mem_read=0; d_mem_ready pulses on mem_ready.
- Simultaneous requests, PRIO_MODE=0:
  - Stimulus: I and D requesting from reset, both held.
  - Required: grants alternate D, I, D. Each transaction is separated by DONE and IDLE, so mem_read/mem_write are low for at least 2 cycles between transactions.
- PRIO_MODE=1 starvation:
  - Stimulus: D requesting continuously while I is pending.
  - Required: every grant goes to D; after d_mem_write drops, I is granted in the next IDLE.
- Reset mid-BUSY:
  - Stimulus: assert proc_reset for 1 cycle while mem_read=1.
  - Required: at the next edge mem_read=0 and both readies are 0; a late mem_ready is ignored; a new request is granted normally afterwards.
- With MEM_ARB_STAT_EN defined:
  - Stimulus: the alternating scenario run for 4 transactions of 3-cycle latency.
  - Required: i_grant_count=2, d_grant_count=2, and the wait counters match the cycle counts computed by the bench.
